// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl
//   Iterative DES key-schedule sequencer. Loads a post-PC-1 key (C0/D0) and
//   hands out the 16 round keys over a valid/ready handshake, K1..K16 for
//   encrypt and K16..K1 for decrypt.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   load key_in and begin a schedule (sampled in IDLE only)
//   decrypt   in   0 = encrypt order, 1 = decrypt order (sampled with start)
//   key_in    in   [55:28] = C0, [27:0] = D0
//   busy      out  schedule in progress
//   rk_valid  out  round key available
//   rk_ready  in   consumer accepts the round key
//   rk_data   out  PC-2 of the current C/D register
//   rk_idx    out  0-based DES round number of rk_data
//   done      out  one-cycle pulse after the 16th key is accepted

// p_box_56_48
//   DES permuted choice 2. Pure wiring: selects 48 of the 56 C/D bits.
// Ports
//   cd_i   in   56-bit {C, D}
//   pc2_o  out  48-bit round key
module p_box_56_48 (
  input  logic [55:0] cd_i,
  output logic [47:0] pc2_o
);
  // Standard PC-2 table, 1-based bit positions counted from the MSB.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2_o[47-i] = cd_i[56-PC2[i]];
  end
endmodule

module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [55:0] key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk_data,
  output logic [3:0]  rk_idx,
  output logic        done
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;

  // Shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1: rounds 0, 1, 8 and 15
  // shift by one, every other round by two.
  function automatic logic shift_two(input logic [3:0] rnd);
    return !(rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15);
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Decrypt starts at K16, whose C16/D16 equals C0/D0 (28 total shifts).
          cd_d    = decrypt ? key_in
                            : {rotl28(key_in[55:28], 1'b0), rotl28(key_in[27:0], 1'b0)};
          cnt_d   = 4'd0;
          dir_d   = decrypt;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (dir_q)
              cd_d = {rotr28(cd_q[55:28], shift_two(4'd15 - cnt_q)),
                      rotr28(cd_q[27:0],  shift_two(4'd15 - cnt_q))};
            else
              cd_d = {rotl28(cd_q[55:28], shift_two(cnt_q + 4'd1)),
                      rotl28(cd_q[27:0],  shift_two(cnt_q + 4'd1))};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs derive only from registers so they drop straight away on reset.
  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign rk_idx   = dir_q ? (4'd15 - cnt_q) : cnt_q;
  assign done     = done_q;

  p_box_56_48 u_pc2 (
    .cd_i  (cd_q),
    .pc2_o (rk_data)
  );
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
module tb_des_key_sched_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [55:0] key_in = '0;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic [47:0] rk_data;
  logic [3:0]  rk_idx;
  logic        done;

  always #5 clk = ~clk;

  des_key_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .decrypt  (decrypt),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  localparam logic [55:0] KEY   = 56'hF0CCAAF556678F;
  localparam logic [55:0] KEY_B = 56'h123456789ABCDE;

  // Round keys K1..K16 of the classic 133457799BBCDFF1 example, worked by hand.
  logic [47:0] rk_tab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic        last;
    logic [3:0]  idx;
    logic [47:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_hs = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  logic        stall_prev = 1'b0;
  logic        last_prev = 1'b0;
  logic [47:0] data_prev;
  logic [3:0]  idx_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      last_prev  = 1'b0;
    end else begin
      if (stall_prev && rk_valid) begin
        check("stall_data", {16'h0, rk_data}, {16'h0, data_prev});
        check("stall_idx", {60'h0, rk_idx}, {60'h0, idx_prev});
      end
      if (done || last_prev) begin
        check("done_timing", {63'h0, done}, {63'h0, last_prev});
        if (done) begin
          check("valid_in_done", {63'h0, rk_valid}, 64'h0);
          n_done++;
        end
      end
      if (rk_valid) check("busy_eq_valid", {63'h0, busy}, 64'h1);
      last_prev = 1'b0;
      if (rk_valid && rk_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("unexpected_key", {16'h0, rk_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rk_idx", {60'h0, rk_idx}, {60'h0, e.idx});
          check("rk_data", {16'h0, rk_data}, {16'h0, e.data});
          last_prev = e.last;
        end
      end
      stall_prev = rk_valid && !rk_ready;
      data_prev  = rk_data;
      idx_prev   = rk_idx;
    end
  end

  task automatic push_sched(input logic dec);
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.idx  = dec ? 4'(15 - i) : 4'(i);
      e.data = rk_tab[e.idx];
      e.last = (i == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [55:0] k, input logic dec);
    @(posedge clk); #1;
    start = 1'b1; key_in = k; decrypt = dec;
    @(posedge clk); #1;
    start = 1'b0; decrypt = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {63'h0, done}, 64'h1);
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget);
    int n;
    n = 0;
    while (!(rk_valid && rk_idx == idx) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx", {60'h0, rk_idx}, {60'h0, idx});
  endtask

  initial begin
    int hs0, d0;
    bit held;
    #12;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_valid", {63'h0, rk_valid}, 64'h0);
    check("rst_idx", {60'h0, rk_idx}, 64'h0);
    check("rst_data", {16'h0, rk_data}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Encrypt, ready held high: expect 16 consecutive valid cycles.
    rk_ready = 1'b1;
    hs0 = n_hs;
    push_sched(1'b0);
    pulse_start(KEY, 1'b0);
    check("first_latency", {63'h0, rk_valid}, 64'h1);
    repeat (15) begin @(posedge clk); #1; end
    check("valid_16th", {60'h0, rk_idx}, 64'd15);
    wait_done(5);
    check("enc_hs", 64'(n_hs - hs0), 64'd16);
    check("enc_q_empty", 64'(exp_q.size()), 64'd0);

    // Decrypt: reverse order.
    hs0 = n_hs;
    push_sched(1'b1);
    pulse_start(KEY, 1'b1);
    check("dec_first_idx", {60'h0, rk_idx}, 64'd15);
    wait_done(30);
    check("dec_hs", 64'(n_hs - hs0), 64'd16);

    // Backpressure with a 10-cycle hold at round 7.
    hs0 = n_hs;
    held = 1'b0;
    push_sched(1'b0);
    pulse_start(KEY, 1'b0);
    for (int c = 0; c < 400 && done !== 1'b1; c++) begin
      if (!held && rk_valid && rk_idx == 4'd7) begin
        held = 1'b1;
        rk_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    check("bp_done", {63'h0, done}, 64'h1);
    check("bp_hs", 64'(n_hs - hs0), 64'd16);
    rk_ready = 1'b1;

    // Start while busy is ignored.
    push_sched(1'b0);
    pulse_start(KEY, 1'b0);
    wait_idx(4'd4, 20);
    start = 1'b1; key_in = KEY_B; decrypt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; decrypt = 1'b0;
    check("busy_hold", {63'h0, busy}, 64'h1);
    wait_done(30);

    // Reset mid-schedule at round 9.
    push_sched(1'b0);
    pulse_start(KEY, 1'b0);
    wait_idx(4'd9, 20);
    d0 = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {63'h0, rk_valid}, 64'h0);
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_idx", {60'h0, rk_idx}, 64'h0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("arst_no_done", 64'(n_done - d0), 64'd0);
    push_sched(1'b0);
    pulse_start(KEY, 1'b0);
    check("post_rst_k1", {16'h0, rk_data}, {16'h0, rk_tab[0]});

    // Back-to-back: start in the done cycle, decrypt.
    wait_done(30);
    start = 1'b1; key_in = KEY; decrypt = 1'b1;
    push_sched(1'b1);
    check("b2b_gap", {63'h0, rk_valid}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; decrypt = 1'b0;
    check("b2b_valid", {63'h0, rk_valid}, 64'h1);
    check("b2b_first", {16'h0, rk_data}, {16'h0, rk_tab[15]});
    wait_done(30);
    @(posedge clk); #1;
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
